// File: rtl/sap_sequencer.sv
// sap_sequencer: SAP T-state sequencer with opcode decode, run/single-step control and HLT.
// Define SAP_EARLY_RETIRE_EN to retire each instruction at its last active T-state.
module sap_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  opcode,
    input  logic        flag_z,
    input  logic        flag_c,
    input  logic        run,
    input  logic        step,
    output logic [14:0] control_word,
    output logic [2:0]  t_state,
    output logic        stopped,
    output logic        halted,
    output logic        instr_done
);
    typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, HALTED, STOP} state_t;
    localparam logic [14:0] PC_INC     = 15'h0001;
    localparam logic [14:0] PC_OUT     = 15'h0002;
    localparam logic [14:0] PC_LOAD    = 15'h0004;
    localparam logic [14:0] MAR_LOAD   = 15'h0008;
    localparam logic [14:0] RAM_OUT    = 15'h0010;
    localparam logic [14:0] RAM_LOAD   = 15'h0020;
    localparam logic [14:0] IR_LOAD    = 15'h0040;
    localparam logic [14:0] IR_OUT     = 15'h0080;
    localparam logic [14:0] A_LOAD     = 15'h0100;
    localparam logic [14:0] A_OUT      = 15'h0200;
    localparam logic [14:0] B_LOAD     = 15'h0400;
    localparam logic [14:0] ALU_OUT    = 15'h0800;
    localparam logic [14:0] ALU_SUB    = 15'h1000;
    localparam logic [14:0] OUT_LOAD   = 15'h2000;
    localparam logic [14:0] FLAGS_LOAD = 15'h4000;
    state_t state, state_next, last_active, retire_state;
    logic   step_q, step_edge, is_hlt, is_mem, is_alu, jump_taken;
    assign step_edge  = step & ~step_q;
    assign is_hlt     = opcode == 4'hf;
    assign is_mem     = opcode inside {4'h0, 4'h1, 4'h2, 4'h3};
    assign is_alu     = opcode inside {4'h1, 4'h2};
    assign jump_taken = opcode == 4'h4 || (opcode == 4'h5 && flag_z) || (opcode == 4'h6 && flag_c);
    assign last_active = (opcode inside {4'h0, 4'h3}) ? T5 :
                         is_alu ? T6 :
                         (opcode inside {4'h4, 4'h5, 4'h6, 4'he, 4'hf}) ? T4 : T3;
`ifdef SAP_EARLY_RETIRE_EN
    assign retire_state = last_active;
`else
    assign retire_state = T6;
`endif
    assign instr_done = state == retire_state && !is_hlt;
    assign t_state    = state == HALTED ? 3'd7 : state;
    assign stopped    = state == STOP;
    assign halted     = state == HALTED;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= STOP;
            step_q <= 1'b0;
        end else begin
            state  <= state_next;
            step_q <= step;
        end
    end
    always_comb begin
        state_next = state;
        if (state == STOP)
            state_next = (run || step_edge) ? T1 : STOP;
        else if (state == T4 && is_hlt)
            state_next = HALTED;
        else if (instr_done)
            state_next = run ? T1 : STOP;
        else if (state != HALTED)
            state_next = state_t'(state + 3'd1);
    end
    // Words past an instruction's last active T-state fall through to zero.
    always_comb begin
        control_word = '0;
        case (state)
            T1: control_word = PC_OUT | MAR_LOAD;
            T2: control_word = PC_INC;
            T3: control_word = RAM_OUT | IR_LOAD;
            T4: control_word = is_mem ? IR_OUT | MAR_LOAD :
                               jump_taken ? IR_OUT | PC_LOAD :
                               opcode == 4'he ? A_OUT | OUT_LOAD : '0;
            T5: control_word = opcode == 4'h0 ? RAM_OUT | A_LOAD :
                               is_alu ? RAM_OUT | B_LOAD :
                               opcode == 4'h3 ? A_OUT | RAM_LOAD : '0;
            T6: control_word = is_alu ? ALU_OUT | A_LOAD | FLAGS_LOAD | (opcode == 4'h2 ? ALU_SUB : '0) : '0;
            default: control_word = '0;
        endcase
    end
endmodule

// File: tb/tb_sap_sequencer.sv
// tb_sap_sequencer: table-driven instruction model checked every cycle, plus directed literal checks.
module tb_sap_sequencer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        flag_z = 1'b0, flag_c = 1'b0, run = 1'b0, step = 1'b0;
    logic [14:0] control_word;
    logic [2:0]  t_state;
    logic        stopped, halted, instr_done;
    int compared = 0, mismatched = 0;
    int ph = -1;
    bit prev_step = 1'b0;

    always #5 clock = ~clock;

    sap_sequencer dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .flag_z(flag_z), .flag_c(flag_c),
        .run(run), .step(step), .control_word(control_word), .t_state(t_state),
        .stopped(stopped), .halted(halted), .instr_done(instr_done)
    );

    task automatic chk(input string nm, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Number of T-states carrying micro-operations for each opcode.
    function automatic int micro_len(input logic [3:0] op);
        case (op)
            4'h0, 4'h3: return 5;
            4'h1, 4'h2: return 6;
            4'h4, 4'h5, 4'h6, 4'he, 4'hf: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int retire_len(input logic [3:0] op);
`ifdef SAP_EARLY_RETIRE_EN
        return micro_len(op);
`else
        return 6;
`endif
    endfunction

    function automatic int exp_word(input logic [3:0] op, input int t, input logic z, input logic c);
        if (t < 0 || t >= micro_len(op)) return 0;
        if (t < 3) return t == 0 ? 'h00A : t == 1 ? 'h001 : 'h050;
        case (op)
            4'h0: return t == 3 ? 'h088 : 'h110;
            4'h1: return t == 3 ? 'h088 : t == 4 ? 'h410 : 'h4900;
            4'h2: return t == 3 ? 'h088 : t == 4 ? 'h410 : 'h5900;
            4'h3: return t == 3 ? 'h088 : 'h220;
            4'h4: return 'h084;
            4'h5: return z ? 'h084 : 0;
            4'h6: return c ? 'h084 : 0;
            4'he: return 'h2200;
            default: return 0;
        endcase
    endfunction

    // ph: -1 stopped, -2 halted, 0..5 = T1..T6
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ph <= -1;
            prev_step <= 1'b0;
        end else begin
            if (ph == -1)
                ph <= (run || (step && !prev_step)) ? 0 : -1;
            else if (ph >= 0) begin
                if (opcode == 4'hf && ph == 3) ph <= -2;
                else if (ph == retire_len(opcode) - 1) ph <= run ? 0 : -1;
                else ph <= ph + 1;
            end
            prev_step <= step;
        end
    end

    always @(negedge clock) begin
        chk("control_word", int'(control_word), exp_word(opcode, ph, flag_z, flag_c));
        chk("t_state", int'(t_state), ph < 0 ? 7 : ph);
        chk("stopped", int'(stopped), int'(ph == -1));
        chk("halted", int'(halted), int'(ph == -2));
        chk("instr_done", int'(instr_done), int'(ph >= 0 && opcode != 4'hf && ph == retire_len(opcode) - 1));
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_t(input int t, input string nm);
        int n = 0;
        while (int'(t_state) != t && n < 40) begin
            cyc();
            n++;
        end
        chk(nm, int'(t_state), t);
    endtask

    task automatic go_stop();
        run = 1'b0;
        wait_t(7, "reach_stop");
    endtask

    initial begin
        int cnt;
        int n;
        cyc(2);
        chk("rst_cw", int'(control_word), 0);
        chk("rst_t_state", int'(t_state), 7);
        chk("rst_stopped", int'(stopped), 1);
        chk("rst_halted", int'(halted), 0);
        chk("rst_done", int'(instr_done), 0);
        reset_n = 1'b1;
        run = 1'b1;
        opcode = 4'h0;
        cyc(); chk("lda_t1", int'(control_word), 'h00A); chk("lda_t1_state", int'(t_state), 0);
        cyc(); chk("lda_t2", int'(control_word), 'h001);
        cyc(); chk("lda_t3", int'(control_word), 'h050);
        cyc(); chk("lda_t4", int'(control_word), 'h088);
        cyc(); chk("lda_t5", int'(control_word), 'h110);
`ifdef SAP_EARLY_RETIRE_EN
        chk("lda_done_t5", int'(instr_done), 1);
        cyc(); chk("lda_next_t1", int'(t_state), 0);
`else
        chk("lda_done_t5", int'(instr_done), 0);
        cyc(); chk("lda_t6_zero", int'(control_word), 0); chk("lda_done_t6", int'(instr_done), 1);
        cyc(); chk("lda_next_t1", int'(t_state), 0);
`endif
        go_stop();
        opcode = 4'h2;
        run = 1'b1;
        wait_t(5, "sub_reach_t6");
        chk("sub_t6", int'(control_word), 'h5900);
        chk("sub_done_t6", int'(instr_done), 1);
        go_stop();
        opcode = 4'h5;
        flag_z = 1'b0;
        run = 1'b1;
        wait_t(3, "jz0_reach_t4");
        chk("jz0_t4", int'(control_word), 0);
        go_stop();
        flag_z = 1'b1;
        run = 1'b1;
        wait_t(3, "jz1_reach_t4");
        chk("jz1_t4", int'(control_word), 'h084);
        go_stop();
        opcode = 4'h6;
        flag_c = 1'b1;
        run = 1'b1;
        wait_t(3, "jc1_reach_t4");
        chk("jc1_t4", int'(control_word), 'h084);
        go_stop();
        opcode = 4'h9;
        step = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (t_state == 3'd0) cnt++;
            if (i == 0) step = 1'b0;
            if (i == 2) step = 1'b1;
            if (i == 3) step = 1'b0;
        end
        chk("step_pulse_count", cnt, 1);
        chk("step_pulse_stopped", int'(stopped), 1);
        step = 1'b1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (t_state == 3'd0) cnt++;
            if (i == 9) step = 1'b0;
        end
        chk("step_held_count", cnt, 1);
        chk("step_held_stopped", int'(stopped), 1);
        opcode = 4'h1;
        run = 1'b1;
        wait_t(4, "add_reach_t5");
        chk("add_t5", int'(control_word), 'h410);
        run = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_cw", int'(control_word), 0);
        chk("async_rst_state", int'(t_state), 7);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("after_rst_stopped", int'(stopped), 1);
        opcode = 4'hf;
        run = 1'b1;
        n = 0;
        while (!halted && n < 40) begin
            cyc();
            n++;
        end
        chk("hlt_halted", int'(halted), 1);
        chk("hlt_cw", int'(control_word), 0);
        chk("hlt_state", int'(t_state), 7);
        for (int i = 0; i < 6; i++) begin
            step = ~step;
            cyc();
        end
        chk("hlt_sticky", int'(halted), 1);
        chk("hlt_sticky_state", int'(t_state), 7);
        run = 1'b0;
        step = 1'b0;
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("hlt_reset_stopped", int'(stopped), 1);
        opcode = 4'he;
        run = 1'b1;
        wait_t(3, "out_reach_t4");
        chk("out_t4", int'(control_word), 'h2200);
`ifdef SAP_EARLY_RETIRE_EN
        chk("out_done_t4", int'(instr_done), 1);
`else
        chk("out_done_t4", int'(instr_done), 0);
        cyc(); chk("out_t5_state", int'(t_state), 4); chk("out_t5_zero", int'(control_word), 0);
        cyc(); chk("out_t6_state", int'(t_state), 5); chk("out_t6_zero", int'(control_word), 0);
        chk("out_done_t6", int'(instr_done), 1);
`endif
        go_stop();
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
